// File: rtl/assoc_search_hf.sv
// Bit-serial associative search: Hamming distance from the query to every class, then nearest-class select.
// Latency D+N+1 edges from start; no backpressure, en is only honoured in IDLE.
module assoc_search_hf #(
  parameter  int DIMENSIONS  = 10000,
  parameter  int NUM_CLASSES = 2,
  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int DW = $clog2(DIMENSIONS + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [DIMENSIONS-1:0]             hv_query,
  input  logic [NUM_CLASSES*DIMENSIONS-1:0] hv_classes,
  output logic                              out,
  output logic                              valid,
  output logic [CW-1:0]                     class_out,
  output logic [DW-1:0]                     dist_out
);

  localparam int IW = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, COMPARE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d;
  logic [DW-1:0] cnt_q [NUM_CLASSES];
  logic [DW-1:0] cnt_d [NUM_CLASSES];
  logic [CW-1:0] k_q, k_d;
  logic [CW-1:0] best_idx_q, best_idx_d;
  logic [DW-1:0] best_dist_q, best_dist_d;
  logic [CW-1:0] class_out_q, class_out_d;
  logic [DW-1:0] dist_out_q, dist_out_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] cur_dist;
  logic [CW-1:0] nb_idx;
  logic [DW-1:0] nb_dist;

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    class_out_d = class_out_q;
    dist_out_d  = dist_out_q;
    valid_d     = 1'b0;
    cur_dist    = '0;
    nb_idx      = best_idx_q;
    nb_dist     = best_dist_q;

    // Mux out the counter of the class under comparison
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (k_q == CW'(c)) cur_dist = cnt_q[c];
    end
    if (cur_dist < best_dist_q) begin
      nb_idx  = k_q;
      nb_dist = cur_dist;
    end

    unique case (state_q)
      IDLE: begin
        if (en) begin
          for (int c = 0; c < NUM_CLASSES; c++) cnt_d[c] = '0;
          bit_idx_d = '0;
          state_d   = COUNT;
        end
      end
      COUNT: begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
          cnt_d[c] = cnt_q[c] + DW'(hv_query[bit_idx_q] ^
                                    hv_classes[c*DIMENSIONS + int'(bit_idx_q)]);
        end
        if (bit_idx_q == IW'(DIMENSIONS - 1)) begin
          bit_idx_d   = '0;
          k_d         = '0;
          best_idx_d  = '0;
          best_dist_d = DW'(DIMENSIONS);
          state_d     = COMPARE;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      COMPARE: begin
        best_idx_d  = nb_idx;
        best_dist_d = nb_dist;
        if (k_q == CW'(NUM_CLASSES - 1)) begin
          class_out_d = nb_idx;
          dist_out_d  = nb_dist;
          valid_d     = 1'b1;
          state_d     = IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
      k_q         <= '0;
      best_idx_q  <= '0;
      best_dist_q <= '0;
      class_out_q <= '0;
      dist_out_q  <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
      class_out_q <= class_out_d;
      dist_out_q  <= dist_out_d;
      valid_q     <= valid_d;
    end
  end

  assign out       = (state_q == IDLE);
  assign valid     = valid_q;
  assign class_out = class_out_q;
  assign dist_out  = dist_out_q;

endmodule
